// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 raster constants and sync helpers
package vga_pkg;

    // Counter width used by the timing generator and the renderer
    localparam int CNT_W = 10;

    // 640x480@60 timing
    localparam int H_ACTIVE_640 = 640;
    localparam int H_FP_640     = 16;
    localparam int H_SYNC_640   = 96;
    localparam int H_BP_640     = 48;
    localparam int H_TOTAL_640  = H_ACTIVE_640 + H_FP_640 + H_SYNC_640 + H_BP_640;

    localparam int V_ACTIVE_480 = 480;
    localparam int V_FP_480     = 10;
    localparam int V_SYNC_480   = 2;
    localparam int V_BP_480     = 33;
    localparam int V_TOTAL_480  = V_ACTIVE_480 + V_FP_480 + V_SYNC_480 + V_BP_480;

    // Sync polarity (level driven while the pulse is active)
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // Bundle carried through the alignment pipeline; hs/vs are pin levels
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    // True when pos lies in [lo, lo+len-1]
    function automatic logic in_window(input logic [CNT_W-1:0] pos, input int lo, input int len);
        return (int'(pos) >= lo) && (int'(pos) < lo + len);
    endfunction

endpackage

// File: rtl/sig_delay.sv
// rtl/sig_delay.sv - fixed-depth register delay line with reset value input
//   clk, rst_n : clock, asynchronous active-low reset
//   rst_val    : value every stage takes during reset
//   d / q      : input, output delayed by DEPTH clk
module sig_delay #(
    parameter int W     = 3,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= rst_val;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync decode and pixel alignment
//   clk, rst_n           : system clock, asynchronous active-low reset
//   h_count, v_count     : raster position for the renderer
//   pix_tick             : counters advance on the next edge
//   frame_start          : one-clk pulse while the raster sits at (0,0)
//   pixel_in             : renderer pixel, PIPE_DLY clk behind the counters
//   vga_hs/vs/de/pix     : registered pin outputs, mutually aligned
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_640,
    parameter int H_FP     = H_FP_640,
    parameter int H_SYNC   = H_SYNC_640,
    parameter int H_BP     = H_BP_640,
    parameter int V_ACTIVE = V_ACTIVE_480,
    parameter int V_FP     = V_FP_480,
    parameter int V_SYNC   = V_SYNC_480,
    parameter int V_BP     = V_BP_480,
    parameter int PIX_DIV  = 1,
    parameter int PIPE_DLY = 1,
    parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             pix_tick,
    output logic             frame_start,
    input  logic             pixel_in,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de,
    output logic             vga_pix
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [1:0]       DIV_LAST = 2'(PIX_DIV - 1);

    logic [1:0] div;

    // Pixel-tick divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (pix_tick) begin
            div <= '0;
        end else begin
            div <= div + 2'd1;
        end
    end

    assign pix_tick = (div == DIV_LAST);

    // Raster counters; v advances on the same edge that wraps h
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pix_tick) begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    assign frame_start = pix_tick && (h_count == '0) && (v_count == '0);

    // Decode at the counters' time, then delay to meet the renderer's pixel
    logic  de_now, hs_act, vs_act;
    sync_t sync_now, sync_dly, sync_rst;

    assign de_now = (h_count < H_VIS) && (v_count < V_VIS);
    assign hs_act = in_window(h_count, H_ACTIVE + H_FP, H_SYNC);
    assign vs_act = in_window(v_count, V_ACTIVE + V_FP, V_SYNC);

    assign sync_now.de = de_now;
    assign sync_now.hs = hs_act ? SYNC_POL : ~SYNC_POL;
    assign sync_now.vs = vs_act ? SYNC_POL : ~SYNC_POL;

    assign sync_rst.de = 1'b0;
    assign sync_rst.hs = ~SYNC_POL;
    assign sync_rst.vs = ~SYNC_POL;

    sig_delay #(
        .W     ($bits(sync_t)),
        .DEPTH (PIPE_DLY)
    ) u_sync_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val (sync_rst),
        .d       (sync_now),
        .q       (sync_dly)
    );

    // Output stage: the renderer pixel arrives alongside the last delay stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hs  <= ~SYNC_POL;
            vga_vs  <= ~SYNC_POL;
            vga_de  <= 1'b0;
            vga_pix <= 1'b0;
        end else begin
            vga_hs  <= sync_dly.hs;
            vga_vs  <= sync_dly.vs;
            vga_de  <= sync_dly.de;
            vga_pix <= pixel_in & sync_dly.de;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of vga_timing_gen (default and reduced timings)
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- instance A: 640x480, PIX_DIV=1, PIPE_DLY=1, active-low
    logic       rst_a = 1'b0;
    logic [9:0] h_a, v_a;
    logic       tick_a, fs_a, pin_a, hs_a, vs_a, de_a, pix_a;
    logic       pix_r, force_one = 1'b0;

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_a), .h_count(h_a), .v_count(v_a),
        .pix_tick(tick_a), .frame_start(fs_a), .pixel_in(pin_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_de(de_a), .vga_pix(pix_a)
    );

    // Renderer model: one registered stage on h[0]
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) pix_r <= 1'b0;
        else        pix_r <= h_a[0];
    end
    assign pin_a = force_one ? 1'b1 : pix_r;

    // ---------------- instance B: 15x8 raster, PIX_DIV=2, PIPE_DLY=2, active-high
    logic       rst_b = 1'b0;
    logic [9:0] h_b, v_b;
    logic       tick_b, fs_b, hs_b, vs_b, de_b, pix_b;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_DIV(2), .PIPE_DLY(2), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .h_count(h_b), .v_count(v_b),
        .pix_tick(tick_b), .frame_start(fs_b), .pixel_in(1'b1),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b), .vga_pix(pix_b)
    );

    typedef struct {
        int k;
        int h, v;
        bit fs, hs, vs, de;
    } vec_t;

    vec_t tbl [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instance A expected values (line 0..2 only, all inside v<480)
    function automatic int ha(input int j); return j % 800; endfunction
    function automatic int va(input int j); return j / 800; endfunction
    function automatic bit dea(input int j); return ha(j) < 640; endfunction
    function automatic bit forced(input int j); return (j >= 800) && (j < 1600); endfunction
    function automatic bit pina(input int j);
        if (forced(j)) return 1'b1;
        if (j < 1)     return 1'b0;
        return ha(j - 1) % 2 == 1;
    endfunction

    // Instance B expected values
    function automatic int hb(input int k); return (k / 2) % 15; endfunction
    function automatic int vb(input int k); return ((k / 2) / 15) % 8; endfunction
    function automatic bit deb(input int k); return (hb(k) < 8) && (vb(k) < 4); endfunction
    function automatic bit hsb(input int k); return (hb(k) >= 10) && (hb(k) <= 12); endfunction
    function automatic bit vsb(input int k); return (vb(k) >= 5) && (vb(k) <= 6); endfunction

    initial begin
        int ti, hs_low, pix_err, fs_cnt, found;
        int e_h, e_v, e_t, e_fs, e_hs, e_vs, e_de, e_px;
        int fs_first, fs_second;

        //            k     h    v  fs hs vs de
        tbl[0]  = '{0,    0,   0, 1, 1, 1, 0};
        tbl[1]  = '{1,    1,   0, 0, 1, 1, 0};
        tbl[2]  = '{2,    2,   0, 0, 1, 1, 1};
        tbl[3]  = '{641,  641, 0, 0, 1, 1, 1};
        tbl[4]  = '{642,  642, 0, 0, 1, 1, 0};
        tbl[5]  = '{657,  657, 0, 0, 1, 1, 0};
        tbl[6]  = '{658,  658, 0, 0, 0, 1, 0};
        tbl[7]  = '{753,  753, 0, 0, 0, 1, 0};
        tbl[8]  = '{754,  754, 0, 0, 1, 1, 0};
        tbl[9]  = '{799,  799, 0, 0, 1, 1, 0};
        tbl[10] = '{800,  0,   1, 0, 1, 1, 0};
        tbl[11] = '{801,  1,   1, 0, 1, 1, 0};
        tbl[12] = '{802,  2,   1, 0, 1, 1, 1};
        tbl[13] = '{1458, 658, 1, 0, 0, 1, 0};

        // Reset held 10 cycles
        repeat (10) @(posedge clk);
        #1;
        chk("rst_h", h_a, 0);
        chk("rst_v", v_a, 0);
        chk("rst_hs", hs_a, 1);
        chk("rst_vs", vs_a, 1);
        chk("rst_de", de_a, 0);
        chk("rst_pix", pix_a, 0);

        // Release A between edges; sample index k follows
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        ti = 0; hs_low = 0; pix_err = 0;
        for (int k = 0; k < 1700; k++) begin
            if (k > 0) begin
                force_one = forced(k) ? 1'b1 : 1'b0;
                step();
            end
            if (ti < 14 && tbl[ti].k == k) begin
                chk($sformatf("h@%0d", k),  h_a,  tbl[ti].h);
                chk($sformatf("v@%0d", k),  v_a,  tbl[ti].v);
                chk($sformatf("fs@%0d", k), fs_a, tbl[ti].fs);
                chk($sformatf("hs@%0d", k), hs_a, tbl[ti].hs);
                chk($sformatf("vs@%0d", k), vs_a, tbl[ti].vs);
                chk($sformatf("de@%0d", k), de_a, tbl[ti].de);
                ti++;
            end
            if (k >= 2 && k < 1602 && hs_a == 1'b0) hs_low++;
            if (k >= 2) begin
                if (pix_a !== (pina(k - 1) & dea(k - 2))) pix_err++;
            end else if (pix_a !== 1'b0) begin
                pix_err++;
            end
        end
        force_one = 1'b0;
        chk("hs_low_2lines", hs_low, 192);
        chk("pix_align_errs", pix_err, 0);

        // Mid-line reset of A at h=300
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (h_a == 10'd300) found = 1;
            else step();
        end
        chk("reach_h300", found, 1);
        chk("pre_rst_de", de_a, 1);
        #2;
        rst_a = 1'b0;
        #1;
        chk("async_h", h_a, 0);
        chk("async_v", v_a, 0);
        chk("async_hs", hs_a, 1);
        chk("async_de", de_a, 0);
        chk("async_pix", pix_a, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        fs_cnt = 0;
        for (int k = 0; k < 800; k++) begin
            if (k > 0) step();
            if (fs_a) fs_cnt++;
            if (k == 5) chk("restart_h5", h_a, 5);
        end
        chk("restart_fs_once", fs_cnt, 1);

        // Instance B: two full frames against the reference raster
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        e_h = 0; e_v = 0; e_t = 0; e_fs = 0; e_hs = 0; e_vs = 0; e_de = 0; e_px = 0;
        fs_first = -1; fs_second = -1;
        for (int k = 0; k < 490; k++) begin
            bit exp_tick, exp_de, exp_hs, exp_vs;
            if (k > 0) step();
            exp_tick = (k % 2) == 1;
            exp_de = (k >= 3) ? deb(k - 3) : 1'b0;
            exp_hs = (k >= 3) ? hsb(k - 3) : 1'b0;
            exp_vs = (k >= 3) ? vsb(k - 3) : 1'b0;
            if (h_b != hb(k)) e_h++;
            if (v_b != vb(k)) e_v++;
            if (tick_b !== exp_tick) e_t++;
            if (fs_b !== (exp_tick && hb(k) == 0 && vb(k) == 0)) e_fs++;
            if (hs_b !== exp_hs) e_hs++;
            if (vs_b !== exp_vs) e_vs++;
            if (de_b !== exp_de) e_de++;
            if (pix_b !== exp_de) e_px++;
            if (fs_b) begin
                if (fs_first < 0) fs_first = k;
                else if (fs_second < 0) fs_second = k;
            end
        end
        chk("b_h_errs", e_h, 0);
        chk("b_v_errs", e_v, 0);
        chk("b_tick_errs", e_t, 0);
        chk("b_fs_errs", e_fs, 0);
        chk("b_hs_errs", e_hs, 0);
        chk("b_vs_errs", e_vs, 0);
        chk("b_de_errs", e_de, 0);
        chk("b_pix_errs", e_px, 0);
        chk("b_fs_first", fs_first, 1);
        chk("b_frame_period", fs_second - fs_first, 240);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing source for the clock display. Generates the 10-bit horizontal and vertical counters that the framebuffer renderer consumes, and the VGA sync pulses. Re-aligns sync and data-enable with the renderer's registered 1-bit pixel so the monitor sees pixel, hsync, vsync and blanking on the same edge. Sits between the top-level clock/reset and the VGA pins; the renderer hangs off its counter outputs and returns `pixel_in`.

## Interface

Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BP`, 48: horizontal back porch (H_TOTAL = 800)
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vsync width
- `V_BP`, 33: vertical back porch (V_TOTAL = 525)
- `PIX_DIV`, 1: clk cycles per pixel tick, 1..4
- `PIPE_DLY`, 1: renderer pixel latency in clk cycles, 1..4
- `SYNC_POL`, 0: active sync level (0 = active-low)

Ports:
- `clk` in 1: single system clock
- `rst_n` in 1: reset, asynchronous, active-low
- `h_count` out 10: current horizontal position, to renderer `horizCounter`
- `v_count` out 10: current vertical position, to renderer `vertCounter`
- `pix_tick` out 1: high in cycles where counters advance on the next edge
- `frame_start` out 1: one-clk pulse at (0,0)
- `pixel_in` in 1: renderer pixel, valid PIPE_DLY cycles after the counters that produced it
- `vga_hs` out 1: aligned hsync
- `vga_vs` out 1: aligned vsync
- `vga_de` out 1: aligned display-enable
- `vga_pix` out 1: `pixel_in` gated by aligned display-enable

## Operation

- Tick divider `div` counts 0..PIX_DIV-1. `pix_tick = (div == PIX_DIV-1)`. With PIX_DIV=1, tick is constant 1 after reset.
- On a clk edge with `pix_tick`:
  - `h_count` increments.
  - At H_TOTAL-1, `h_count` wraps to 0 and `v_count` increments.
  - `v_count` wraps to 0 at V_TOTAL-1 when `h_count` also wraps.
- Decodes are combinational on the current counters:
  - de = h<H_ACTIVE && v<V_ACTIVE
  - hs = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
- Active hs/vs drive SYNC_POL on the pins; inactive drives ~SYNC_POL.
- `frame_start = pix_tick && h==0 && v==0` (combinational).
- Delay line of PIPE_DLY registers carries {de, hs, vs}. Output registers load the last stage:
  - `vga_pix <= pixel_in & de_d[PIPE_DLY-1]`
  - `vga_hs`, `vga_vs`, `vga_de` load the matching delayed bits.
- Counters are never stalled. Rendering and framebuffer state do not affect timing.

## Timing

- Reset (asynchronous assert, synchronous-to-clk deassert by top level):
  - `div`, `h_count`, `v_count` = 0
  - `vga_de` = 0, `vga_pix` = 0
  - `vga_hs`, `vga_vs` = ~SYNC_POL
  - All delay stages hold {0, inactive, inactive}
- First cycle after release (PIX_DIV=1): `frame_start` = 1, since the counters sit at (0,0).
- Latency: aligned outputs at cycle n+PIPE_DLY+1 reflect counters at cycle n. Counter outputs have zero latency (registered state).
- Wrap: h=799 → 0 in the same edge that increments v. Edge from (799,524) → (0,0), after which `frame_start` fires.
- Period: one line = H_TOTAL × PIX_DIV clk. One frame = H_TOTAL × V_TOTAL × PIX_DIV clk.
- `rst_n` low mid-line: everything returns to reset values immediately. Restart is at (0,0); no partial-line recovery.
- `pixel_in` is ignored whenever the delayed de is 0.

## Structure

- Shared package `vga_pkg` holds:
  - 640×480@60 timing constants and derived H_TOTAL/V_TOTAL
  - counter width constant (10)
  - sync polarity constants
- The renderer imports the same package for its display-area checks.
- One sub-module, `sig_delay` (parameterised width and depth, async active-low reset value input), is used for the {de, hs, vs} pipeline.
- Estimated 150–250 lines total.

## Test plan

- **Reset and first frame:** hold `rst_n`=0 10 cycles, release, PIX_DIV=1.
  - `h_count`=`v_count`=0, `frame_start`=1 on the first cycle.
  - `vga_hs`=`vga_vs`=1, `vga_de`=0 for the first PIPE_DLY+1 cycles.
- **Line timing:** run 2 lines.
  - hsync low for exactly 96 ticks, starting at h=656.
  - `vga_hs` falls 2 cycles later (PIPE_DLY=1).
  - `v_count` steps 0→1 on the edge where h 799→0.
- **Frame timing:** run a full frame.
  - vsync active for lines 490–491 only.
  - `frame_start` period exactly 420000 cycles.
  - (799,524)→(0,0) wrap observed.
- **Pixel alignment:** model the renderer as `pixel_in` = registered (h[0]).
  - `vga_pix` equals h[0] of the counter sampled 2 cycles earlier inside the active area.
  - `vga_pix` is 0 for h≥640 even with `pixel_in`=1.
- **Divider:** PIX_DIV=2.
  - `pix_tick` alternates 0/1.
  - `h_count` advances every 2 clk; line = 1600 clk.
- **Mid-operation reset:** assert `rst_n` at h=300, v=200 between edges.
  - Outputs go to reset values without waiting for a clk edge.
  - After release, counting restarts from (0,0) and `frame_start` pulses once.
